// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus an MMIO block with a cycle counter,
// a compare/match flag and a TX FIFO drained over a valid/ready handshake.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        match_irq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] REG_CYCLE  = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CMP    = 2'd3;

  logic [31:0]   ram  [RAM_WORDS];
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycle_q, cmp_q;
  logic          ovf_q, match_q;

  logic          ram_hit, mmio_hit;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_ram, wr_cycle, wr_tx, wr_status, wr_cmp;
  logic          empty, full, pop, push, match_set;
  logic [31:0]   status;

  // Address decode, FIFO handshake and combinational read mux
  always_comb begin
    ram_hit   = ALUResult < 32'(RAM_WORDS * 4);
    mmio_hit  = ALUResult[31:4] == MMIO_BASE[31:4];
    reg_sel   = ALUResult[3:2];
    ram_idx   = ALUResult[AW+1:2];
    wr_ram    = MemWrite && ram_hit;
    wr_cycle  = MemWrite && mmio_hit && (reg_sel == REG_CYCLE);
    wr_tx     = MemWrite && mmio_hit && (reg_sel == REG_TXDATA);
    wr_status = MemWrite && mmio_hit && (reg_sel == REG_STATUS);
    wr_cmp    = MemWrite && mmio_hit && (reg_sel == REG_CMP);
    empty     = count == '0;
    full      = count == CW'(FIFO_DEPTH);
    pop       = !empty && tx_ready;
    push      = wr_tx && (!full || pop);
    match_set = (cycle_q == cmp_q) && (cmp_q != 32'd0);
    status    = {16'd0, 8'(count), 4'd0, match_q, ovf_q, full, empty};

    ReadData = 32'd0;
    if (ram_hit) begin
      ReadData = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_CYCLE:  ReadData = cycle_q;
        REG_STATUS: ReadData = status;
        REG_CMP:    ReadData = cmp_q;
        default:    ReadData = 32'd0;
      endcase
    end
  end

  assign tx_valid  = !empty;
  assign tx_data   = empty ? 32'd0 : fifo[rd_ptr];
  assign match_irq = match_q;

  // Storage arrays carry no reset; the FIFO head is masked while empty
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= WriteData;
    if (push)   fifo[wr_ptr] <= WriteData;
  end

  // Control state: counter, compare, sticky flags, FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= 32'd0;
      cmp_q   <= 32'd0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      cycle_q <= wr_cycle ? 32'd0 : cycle_q + 32'd1;
      if (wr_cmp) cmp_q <= WriteData;

      // A new event outranks a same-cycle write-1-to-clear
      if (wr_tx && full && !pop)            ovf_q <= 1'b1;
      else if (wr_status && WriteData[2])   ovf_q <= 1'b0;
      if (match_set)                        match_q <= 1'b1;
      else if (wr_status && WriteData[3])   match_q <= 1'b0;

      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
